// File: rtl/uart_core_param.sv
// uart_core_param -- parametrised UART transceiver.
//
// Purpose:
//   Ready/valid TX and RX over an asynchronous serial line. The RX path is
//   16x (OVERSAMPLE) oversampled with a start-bit glitch filter. Received
//   bytes go into a first-word-fall-through FIFO with overrun detection.
//   Frames: 1 start bit, DATA_BITS data bits (LSB first), optional parity
//   bit, STOP_BITS stop bits.
//
// Optional feature macro:
//   UART_PARITY_EN -- adds a parity bit (even unless PARITY_ODD=1) on TX
//                     and a parity check on RX. When it is undefined,
//                     rx_parity_err is tied to 0.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous reset, active low
//   rx_i          in   serial input, asynchronous, idle high
//   tx_o          out  serial output, idle high
//   tx_valid      in   TX byte offered
//   tx_ready      out  TX accepts (only while the TX FSM is idle)
//   tx_data       in   TX payload, DATA_BITS wide
//   tx_busy       out  TX frame in progress (== !tx_ready)
//   rx_valid      out  RX FIFO non-empty
//   rx_ready      in   pop the RX FIFO head
//   rx_data       out  RX FIFO head (0 while empty)
//   rx_frame_err  out  1-clk pulse: first stop bit sampled low
//   rx_parity_err out  1-clk pulse: parity mismatch
//   rx_overrun    out  1-clk pulse: good byte dropped because FIFO full
module uart_core_param #(
  parameter int CLK_HZ        = 40000000,
  parameter int BAUD          = 9600,
  parameter int OVERSAMPLE    = 16,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic                 tx_o,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int TICK_DIV  = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int BIT_CLKS  = TICK_DIV * OVERSAMPLE;
  localparam int STOP_CLKS = STOP_BITS * BIT_CLKS;
  localparam int TCW       = $clog2(STOP_CLKS + 1);
  localparam int IDXW      = $clog2(DATA_BITS);
  localparam int TKW       = $clog2(TICK_DIV + 1);
  localparam int SCW       = $clog2(OVERSAMPLE);
  localparam int AW        = $clog2(RX_FIFO_DEPTH);

  localparam logic [TCW-1:0]  BIT_LAST  = TCW'(BIT_CLKS - 1);
  localparam logic [TCW-1:0]  STOP_LAST = TCW'(STOP_CLKS - 1);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DATA_BITS - 1);
  localparam logic [TKW-1:0]  TICK_LAST = TKW'(TICK_DIV - 1);
  localparam logic [SCW-1:0]  HALF_LAST = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0]  FULL_LAST = SCW'(OVERSAMPLE - 1);

`ifdef UART_PARITY_EN
  localparam logic PARITY_ODD = 1'b0;
`endif

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  tx_state_t             tx_state_reg, tx_state_next;
  logic [TCW-1:0]        tx_cnt_reg, tx_cnt_next;
  logic [IDXW-1:0]       tx_idx_reg, tx_idx_next;
  logic [DATA_BITS-1:0]  tx_shift_reg, tx_shift_next;
  logic                  tx_line_reg, tx_line_next;
`ifdef UART_PARITY_EN
  logic                  tx_par_reg, tx_par_next;
`endif

  // tx_line_reg is loaded with the level of the state being entered, so the
  // pin comes straight from a flop and never glitches on state decode.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg + 1'b1;
    tx_idx_next   = tx_idx_reg;
    tx_shift_next = tx_shift_reg;
    tx_line_next  = tx_line_reg;
`ifdef UART_PARITY_EN
    tx_par_next   = tx_par_reg;
`endif
    case (tx_state_reg)
      TX_IDLE: begin
        tx_cnt_next  = '0;
        tx_line_next = 1'b1;
        if (tx_valid) begin
          tx_state_next = TX_START;
          tx_shift_next = tx_data;
          tx_idx_next   = '0;
          tx_line_next  = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_next   = (^tx_data) ^ PARITY_ODD;
`endif
        end
      end
      TX_START: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = TX_DATA;
          tx_line_next  = tx_shift_reg[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next = '0;
          if (tx_idx_reg == IDX_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_next = TX_PARITY;
            tx_line_next  = tx_par_reg;
`else
            tx_state_next = TX_STOP;
            tx_line_next  = 1'b1;
`endif
          end else begin
            tx_idx_next   = tx_idx_reg + 1'b1;
            tx_shift_next = tx_shift_reg >> 1;
            tx_line_next  = tx_shift_reg[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = TX_STOP;
          tx_line_next  = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (tx_cnt_reg == STOP_LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = TX_IDLE;
          tx_line_next  = 1'b1;
        end
      end
      default: begin
        tx_state_next = TX_IDLE;
        tx_cnt_next   = '0;
        tx_line_next  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_idx_reg   <= '0;
      tx_shift_reg <= '0;
      tx_line_reg  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_reg   <= 1'b0;
`endif
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_idx_reg   <= tx_idx_next;
      tx_shift_reg <= tx_shift_next;
      tx_line_reg  <= tx_line_next;
`ifdef UART_PARITY_EN
      tx_par_reg   <= tx_par_next;
`endif
    end
  end

  assign tx_o     = tx_line_reg;
  assign tx_ready = (tx_state_reg == TX_IDLE);
  assign tx_busy  = !tx_ready;

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT     // after a framing error: wait for the line to return high
  } rx_state_t;

  logic                 rx_meta_reg, rx_sync_reg;
  rx_state_t            rx_state_reg, rx_state_next;
  logic [TKW-1:0]       rx_tick_cnt_reg, rx_tick_cnt_next;
  logic [SCW-1:0]       rx_samp_cnt_reg, rx_samp_cnt_next;
  logic [IDXW-1:0]      rx_idx_reg, rx_idx_next;
  logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic                 rx_push_reg, rx_push_next;
  logic                 rx_ferr_reg, rx_ferr_next;
  logic                 rx_perr_reg, rx_perr_next;
  logic                 rx_tick;
`ifdef UART_PARITY_EN
  logic                 rx_par_reg, rx_par_next;
`endif

  assign rx_tick = (rx_tick_cnt_reg == TICK_LAST);

  always_comb begin
    rx_state_next    = rx_state_reg;
    rx_tick_cnt_next = rx_tick ? '0 : rx_tick_cnt_reg + 1'b1;
    rx_samp_cnt_next = rx_tick ? rx_samp_cnt_reg + 1'b1 : rx_samp_cnt_reg;
    rx_idx_next      = rx_idx_reg;
    rx_shift_next    = rx_shift_reg;
    rx_push_next     = 1'b0;
    rx_ferr_next     = 1'b0;
    rx_perr_next     = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_next      = rx_par_reg;
`endif
    case (rx_state_reg)
      RX_IDLE: begin
        rx_tick_cnt_next = '0;
        rx_samp_cnt_next = '0;
        if (!rx_sync_reg) rx_state_next = RX_START;
      end
      RX_START: begin
        // Half a bit in: a line already back high was a glitch.
        if (rx_tick && rx_samp_cnt_reg == HALF_LAST) begin
          rx_samp_cnt_next = '0;
          rx_idx_next      = '0;
          rx_state_next    = rx_sync_reg ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick && rx_samp_cnt_reg == FULL_LAST) begin
          rx_samp_cnt_next = '0;
          rx_shift_next    = {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
          if (rx_idx_reg == IDX_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_next = RX_PARITY;
`else
            rx_state_next = RX_STOP;
`endif
          end else begin
            rx_idx_next = rx_idx_reg + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_tick && rx_samp_cnt_reg == FULL_LAST) begin
          rx_samp_cnt_next = '0;
          rx_par_next      = rx_sync_reg;
          rx_state_next    = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        // Framing error wins over parity error for the same frame.
        if (rx_tick && rx_samp_cnt_reg == FULL_LAST) begin
          rx_samp_cnt_next = '0;
          if (!rx_sync_reg) begin
            rx_ferr_next  = 1'b1;
            rx_state_next = RX_WAIT;
          end else begin
            rx_state_next = RX_IDLE;
`ifdef UART_PARITY_EN
            if (rx_par_reg != ((^rx_shift_reg) ^ PARITY_ODD)) rx_perr_next = 1'b1;
            else                                               rx_push_next = 1'b1;
`else
            rx_push_next = 1'b1;
`endif
          end
        end
      end
      RX_WAIT: begin
        rx_tick_cnt_next = '0;
        rx_samp_cnt_next = '0;
        if (rx_sync_reg) rx_state_next = RX_IDLE;
      end
      default: begin
        rx_state_next    = RX_IDLE;
        rx_tick_cnt_next = '0;
        rx_samp_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_reg     <= 1'b1;
      rx_sync_reg     <= 1'b1;
      rx_state_reg    <= RX_IDLE;
      rx_tick_cnt_reg <= '0;
      rx_samp_cnt_reg <= '0;
      rx_idx_reg      <= '0;
      rx_shift_reg    <= '0;
      rx_push_reg     <= 1'b0;
      rx_ferr_reg     <= 1'b0;
      rx_perr_reg     <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_reg      <= 1'b0;
`endif
    end else begin
      rx_meta_reg     <= rx_i;
      rx_sync_reg     <= rx_meta_reg;
      rx_state_reg    <= rx_state_next;
      rx_tick_cnt_reg <= rx_tick_cnt_next;
      rx_samp_cnt_reg <= rx_samp_cnt_next;
      rx_idx_reg      <= rx_idx_next;
      rx_shift_reg    <= rx_shift_next;
      rx_push_reg     <= rx_push_next;
      rx_ferr_reg     <= rx_ferr_next;
      rx_perr_reg     <= rx_perr_next;
`ifdef UART_PARITY_EN
      rx_par_reg      <= rx_par_next;
`endif
    end
  end

  assign rx_frame_err  = rx_ferr_reg;
  assign rx_parity_err = rx_perr_reg;

  // -------------------------------------------------------------- FIFO
  // rx_shift_reg is stable while the FSM sits in IDLE, so the push one
  // clock after the stop sample still writes the completed byte.
  logic [DATA_BITS-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [AW:0]          wr_ptr_reg, rd_ptr_reg;
  logic                 fifo_empty, fifo_full, fifo_rd, fifo_wr;
  logic                 rx_ovr_reg;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign fifo_rd    = !fifo_empty && rx_ready;
  // A simultaneous pop frees the slot, so a full FIFO can still accept.
  assign fifo_wr    = rx_push_reg && (!fifo_full || fifo_rd);

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_reg[AW-1:0]] <= rx_shift_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      rx_ovr_reg <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      rx_ovr_reg <= rx_push_reg && fifo_full && !fifo_rd;
    end
  end

  assign rx_valid   = !fifo_empty;
  assign rx_data    = fifo_empty ? '0 : fifo_mem[rd_ptr_reg[AW-1:0]];
  assign rx_overrun = rx_ovr_reg;

endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param -- directed, self-checking bench for uart_core_param.
// Runs at CLK_HZ=1600000, BAUD=10000, OVERSAMPLE=16 (TICK_DIV=10,
// BIT_CLKS=160). Expected RX bytes are queued when stimulus is driven and
// popped when the DUT presents them.
module tb_uart_core_param;

  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_o, tx_ready, tx_busy, tx_valid;
  logic [7:0] tx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] rx_data;
  logic       rx_frame_err, rx_parity_err, rx_overrun;
  logic       rx_drv, loopback, rx_line;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ferr = 0, n_perr = 0, n_ovr = 0;
  logic [7:0] exp_q [$];

`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = 1'b0;
  logic par_flip = 1'b0;
`endif

  assign rx_line = loopback ? tx_o : rx_drv;

  always #5 clk = ~clk;

  uart_core_param #(
    .CLK_HZ(1600000), .BAUD(10000), .OVERSAMPLE(16),
    .DATA_BITS(8), .STOP_BITS(1), .RX_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_line), .tx_o(tx_o),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
  );

  // Pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rx_frame_err)  n_ferr++;
    if (rx_parity_err) n_perr++;
    if (rx_overrun)    n_ovr++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no finish, expected finish before 5 ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tx_send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~d;   // later changes must not reach the line
  endtask

  task automatic wait_tx_idle(input string tag, input int limit);
    int n = 0;
    while (!tx_ready && n < limit) begin @(negedge clk); n++; end
    check(tag, tx_ready, 1);
  endtask

  task automatic send_serial(input logic [7:0] d, input logic stop_val);
    rx_drv = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx_drv = (^d) ^ PAR_ODD ^ par_flip;
    repeat (BIT_CLKS) @(negedge clk);
`endif
    rx_drv = stop_val;
    repeat (BIT_CLKS) @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // Wait for the FIFO head, then compare it with the scoreboard front.
  task automatic wait_rx(input string tag, input int limit);
    int n = 0;
    logic [7:0] e;
    while (!rx_valid && n < limit) begin @(negedge clk); n++; end
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_qsize"}, (exp_q.size() > 0), 1);
    if (rx_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, rx_data, e);
    end
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    int ok_bit [10];
    int ok_busy;
    int f0, p0, o0;
    logic [7:0] d;
    logic [9:0] frame;

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    rx_drv = 1'b1; loopback = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_tx_o", tx_o, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_errs", {rx_frame_err, rx_parity_err, rx_overrun}, 0);

    // 1. TX waveform of 8'hA5 (no parity build: 10 bits of 160 clks)
    d = 8'hA5;
    frame = {1'b1, d, 1'b0};
    ok_busy = 0;
    for (int k = 0; k < 10; k++) ok_bit[k] = 0;
    tx_send(d);
    for (int i = 0; i < 10 * BIT_CLKS; i++) begin
      if (i > 0) @(negedge clk);
`ifndef UART_PARITY_EN
      if (tx_o === frame[i / BIT_CLKS]) ok_bit[i / BIT_CLKS]++;
`endif
      if (tx_ready === 1'b0 && tx_busy === 1'b1) ok_busy++;
    end
`ifndef UART_PARITY_EN
    for (int k = 0; k < 10; k++) check($sformatf("t1_bit%0d_clks", k), ok_bit[k], BIT_CLKS);
    check("t1_busy_clks", ok_busy, 10 * BIT_CLKS);
`endif
    @(negedge clk);
`ifndef UART_PARITY_EN
    check("t1_ready_after", tx_ready, 1);
`endif
    wait_tx_idle("t1_idle", 400);
    check("t1_line_idle", tx_o, 1);

    // 2. Loopback 8'h3C
    loopback = 1'b1;
    repeat (5) @(negedge clk);
    tx_send(8'h3C);
    exp_q.push_back(8'h3C);
    wait_rx("t2", 1601 + 160);
    pop_one();
    check("t2_empty_after_pop", rx_valid, 0);
    wait_tx_idle("t2_idle", 2000);
    loopback = 1'b0;
    repeat (20) @(negedge clk);

    // 3. 40-clk glitch, then a real 8'h55 frame
    f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
    rx_drv = 1'b0;
    repeat (40) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check("t3_glitch_valid", rx_valid, 0);
    check("t3_glitch_errs", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
    send_serial(8'h55, 1'b1);
    exp_q.push_back(8'h55);
    wait_rx("t3", 200);
    pop_one();

    // 4. Frame 8'h81 with stop bit low
    f0 = n_ferr; p0 = n_perr;
    send_serial(8'h81, 1'b0);
    repeat (50) @(negedge clk);
    check("t4_ferr_pulses", n_ferr - f0, 1);
    check("t4_perr_pulses", n_perr - p0, 0);
    check("t4_valid", rx_valid, 0);

    // 5. Overrun: five bytes into a four-entry FIFO with no pops
    o0 = n_ovr;
    for (int b = 1; b <= 5; b++) begin
      send_serial(8'(b), 1'b1);
      if (b <= 4) exp_q.push_back(8'(b));
      if (b == 4) check("t5_no_ovr_yet", n_ovr - o0, 0);
    end
    check("t5_ovr_pulses", n_ovr - o0, 1);
    for (int b = 1; b <= 4; b++) begin
      wait_rx($sformatf("t5_pop%0d", b), 0);
      pop_one();
    end
    check("t5_drained", rx_valid, 0);

    // 6. Reset mid-frame (bit 3) with one byte left in the FIFO
    send_serial(8'h99, 1'b1);
    check("t6_fifo_loaded", rx_valid, 1);
    tx_send(8'hF0);
    repeat (BIT_CLKS + 3 * BIT_CLKS + 50) @(negedge clk);
    check("t6_busy_before", tx_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_tx_o", tx_o, 1);
    check("t6_tx_ready", tx_ready, 1);
    check("t6_fifo_flushed", rx_valid, 0);
    loopback = 1'b1;
    repeat (5) @(negedge clk);
    tx_send(8'hC3);
    exp_q.push_back(8'hC3);
    wait_rx("t6_resend", 1800);
    pop_one();
    wait_tx_idle("t6_idle", 2000);
    loopback = 1'b0;
    repeat (20) @(negedge clk);

`ifdef UART_PARITY_EN
    // 7. Wrong parity on 8'h07
    p0 = n_perr; f0 = n_ferr;
    par_flip = 1'b1;
    send_serial(8'h07, 1'b1);
    par_flip = 1'b0;
    repeat (50) @(negedge clk);
    check("t7_perr_pulses", n_perr - p0, 1);
    check("t7_ferr_pulses", n_ferr - f0, 0);
    check("t7_discarded", rx_valid, 0);
`else
    check("no_parity_pulses", n_perr, 0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
